// File: rtl/equiv_result_logger.sv
// Equivalence response logger: compares spec/impl outputs per vector, counts and buffers failures.
// Optional macro EQUIV_LOG_DIFF_EN stores spec^impl per entry and drives log_diff; otherwise log_diff is 0.
module equiv_result_logger #(
  parameter int STIM_W = 12,
  parameter int OUT_W  = 20,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_start,
  input  logic [CNT_W-1:0]  run_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STIM_W-1:0] in_stim,
  input  logic [OUT_W-1:0]  spec_out,
  input  logic [OUT_W-1:0]  impl_out,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [STIM_W-1:0] log_stim,
  output logic [OUT_W-1:0]  log_spec,
  output logic [OUT_W-1:0]  log_impl,
  output logic [CNT_W-1:0]  log_index,
  output logic [OUT_W-1:0]  log_diff,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              overflow,
  output logic              done,
  output logic              pass
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             overflow_q, overflow_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [STIM_W-1:0] stim_mem [DEPTH];
  logic [OUT_W-1:0]  spec_mem [DEPTH];
  logic [OUT_W-1:0]  impl_mem [DEPTH];
  logic [CNT_W-1:0]  idx_mem  [DEPTH];
`ifdef EQUIV_LOG_DIFF_EN
  logic [OUT_W-1:0]  diff_mem [DEPTH];
`endif

  logic start_s, in_ready_s, accept_s, mismatch_s;
  logic empty_s, full_s, pop_s, push_req_s, push_s, drop_s;
  logic [AW:0] fill_s;

  always_comb begin
    start_s    = run_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // run_len = 0 leaves remaining at zero, so nothing is accepted before DRAIN
    in_ready_s = (state_q == S_RUN) && (remaining_q != '0);
    accept_s   = in_valid && in_ready_s;
    mismatch_s = (spec_out != impl_out);
    fill_s     = wr_ptr_q - rd_ptr_q;
    empty_s    = (fill_s == '0);
    full_s     = (fill_s == FIFO_FULL);
    pop_s      = !empty_s && log_ready;
    push_req_s = accept_s && mismatch_s;
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    vec_count_d  = vec_count_q;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (start_s) begin
      state_d      = S_RUN;
      remaining_d  = run_len;
      vec_count_d  = '0;
      fail_count_d = '0;
      overflow_d   = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end else begin
      remaining_d  = accept_s ? remaining_q - CNT_ONE : remaining_q;
      vec_count_d  = accept_s ? sat_inc(vec_count_q) : vec_count_q;
      fail_count_d = push_req_s ? sat_inc(fail_count_q) : fail_count_q;
      overflow_d   = overflow_q | drop_s;
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN: begin
          if ((remaining_q == '0) || (accept_s && (remaining_q == CNT_ONE))) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (empty_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      vec_count_q  <= '0;
      fail_count_q <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      vec_count_q  <= vec_count_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: every read is masked by log_valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      stim_mem[wr_ptr_q[AW-1:0]] <= in_stim;
      spec_mem[wr_ptr_q[AW-1:0]] <= spec_out;
      impl_mem[wr_ptr_q[AW-1:0]] <= impl_out;
      idx_mem[wr_ptr_q[AW-1:0]]  <= vec_count_q;
`ifdef EQUIV_LOG_DIFF_EN
      diff_mem[wr_ptr_q[AW-1:0]] <= spec_out ^ impl_out;
`endif
    end
  end

  assign in_ready   = in_ready_s;
  assign log_valid  = !empty_s;
  assign log_stim   = log_valid ? stim_mem[rd_ptr_q[AW-1:0]] : '0;
  assign log_spec   = log_valid ? spec_mem[rd_ptr_q[AW-1:0]] : '0;
  assign log_impl   = log_valid ? impl_mem[rd_ptr_q[AW-1:0]] : '0;
  assign log_index  = log_valid ? idx_mem[rd_ptr_q[AW-1:0]] : '0;
`ifdef EQUIV_LOG_DIFF_EN
  assign log_diff   = log_valid ? diff_mem[rd_ptr_q[AW-1:0]] : '0;
`else
  assign log_diff   = '0;
`endif
  assign vec_count  = vec_count_q;
  assign fail_count = fail_count_q;
  assign overflow   = overflow_q;
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (fail_count_q == '0);
endmodule

// File: tb/tb_equiv_result_logger.sv
// Scoreboard bench for equiv_result_logger: directed runs push expected log entries, a monitor pops and compares.
module tb_equiv_result_logger;
  localparam int STIM_W = 12;
  localparam int OUT_W  = 20;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_start = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [STIM_W-1:0] in_stim = '0;
  logic [OUT_W-1:0] spec_out = '0;
  logic [OUT_W-1:0] impl_out = '0;
  logic log_valid;
  logic log_ready = 1'b0;
  logic [STIM_W-1:0] log_stim;
  logic [OUT_W-1:0] log_spec, log_impl, log_diff;
  logic [CNT_W-1:0] log_index, vec_count, fail_count;
  logic overflow, done, pass;

  typedef struct {
    logic [STIM_W-1:0] stim;
    logic [OUT_W-1:0]  spec;
    logic [OUT_W-1:0]  impl;
    logic [CNT_W-1:0]  idx;
    logic [OUT_W-1:0]  diff;
  } ent_t;
  ent_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int vec_no = 0;

  equiv_result_logger #(.STIM_W(STIM_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run_start(run_start), .run_len(run_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_stim(in_stim),
    .spec_out(spec_out), .impl_out(impl_out),
    .log_valid(log_valid), .log_ready(log_ready), .log_stim(log_stim),
    .log_spec(log_spec), .log_impl(log_impl), .log_index(log_index),
    .log_diff(log_diff), .vec_count(vec_count), .fail_count(fail_count),
    .overflow(overflow), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] len);
    run_start = 1'b1;
    run_len = len;
    tick();
    run_start = 1'b0;
    vec_no = 0;
  endtask

  task automatic send(input logic [STIM_W-1:0] st, input logic [OUT_W-1:0] sp,
                      input logic [OUT_W-1:0] im, input bit logged);
    ent_t e;
    int g = 0;
    in_valid = 1'b1;
    in_stim = st;
    spec_out = sp;
    impl_out = im;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      if (logged) begin
        e.stim = st; e.spec = sp; e.impl = im;
        e.idx = CNT_W'(vec_no);
`ifdef EQUIV_LOG_DIFF_EN
        e.diff = sp ^ im;
`else
        e.diff = '0;
`endif
        exp_q.push_back(e);
      end
      vec_no++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks head stability under backpressure
  logic hold_q = 1'b0;
  logic [STIM_W-1:0] h_stim;
  logic [CNT_W-1:0]  h_idx;
  logic [OUT_W-1:0]  h_spec, h_impl;
  always @(negedge clk) begin
    ent_t e;
    if (!reset) begin
      if (hold_q) begin
        check("hold_stim", log_stim, h_stim);
        check("hold_index", log_index, h_idx);
        check("hold_spec", log_spec, h_spec);
        check("hold_impl", log_impl, h_impl);
      end
      if (log_valid && exp_q.size() == 0) begin
        check("log_unexpected", log_valid, 0);
      end else if (log_valid && log_ready) begin
        e = exp_q.pop_front();
        check("log_stim", log_stim, e.stim);
        check("log_spec", log_spec, e.spec);
        check("log_impl", log_impl, e.impl);
        check("log_index", log_index, e.idx);
        check("log_diff", log_diff, e.diff);
      end
      hold_q = log_valid && !log_ready;
      h_stim = log_stim; h_idx = log_index; h_spec = log_spec; h_impl = log_impl;
    end else begin
      hold_q = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_log_valid", log_valid, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_log_index", log_index, 0);

    // All-pass run of 8
    log_ready = 1'b1;
    start_run(20'd8);
    for (int i = 0; i < 8; i++) begin
      send(STIM_W'(i * 273), OUT_W'(i * 4369 + 5), OUT_W'(i * 4369 + 5), 1'b0);
    end
    wait_done(20);
    check("allpass_vec", vec_count, 8);
    check("allpass_fail", fail_count, 0);
    check("allpass_pass", pass, 1);
    check("allpass_ovf", overflow, 0);

    // Single failure at index 2, held by backpressure
    log_ready = 1'b0;
    start_run(20'd4);
    send(12'h001, 20'h0000A, 20'h0000A, 1'b0);
    send(12'h002, 20'h0000B, 20'h0000B, 1'b0);
    send(12'hA5C, 20'h12345, 20'h12305, 1'b1);
    send(12'h004, 20'h0000C, 20'h0000C, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("single_done_held", done, 0);
    check("single_in_ready", in_ready, 0);
    check("single_head_index", log_index, 2);
    check("single_head_stim", log_stim, 12'hA5C);
`ifdef EQUIV_LOG_DIFF_EN
    check("single_head_diff", log_diff, 20'h00040);
`else
    check("single_head_diff", log_diff, 20'h00000);
`endif
    log_ready = 1'b1;
    wait_done(10);
    check("single_pass", pass, 0);
    check("single_fail", fail_count, 1);
    check("single_vec", vec_count, 4);

    // Overflow: 6 failures into a 4-deep log, then DRAIN backpressure
    log_ready = 1'b0;
    start_run(20'd6);
    for (int i = 0; i < 6; i++) begin
      send(STIM_W'(12'h100 + i), OUT_W'(20'h00100 + i), OUT_W'((20'h00100 + i) ^ (20'h1 << i)), i < 4);
    end
    in_valid = 1'b1;
    in_stim = 12'hFFF; spec_out = 20'h1; impl_out = 20'h2;
    for (int i = 0; i < 3; i++) begin
      check("drain_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("ovf_vec", vec_count, 6);
    check("ovf_fail", fail_count, 6);
    check("ovf_flag", overflow, 1);
    check("ovf_done_held", done, 0);
    for (int i = 0; i < 40 && !done; i++) begin
      log_ready = i[0];
      tick();
    end
    wait_done(10);
    check("ovf_all_popped", exp_q.size(), 0);
    check("ovf_pass", pass, 0);

    // Restart from DONE, then push+pop on a full log
    log_ready = 1'b0;
    start_run(20'd5);
    check("restart_vec", vec_count, 0);
    check("restart_fail", fail_count, 0);
    check("restart_ovf", overflow, 0);
    check("restart_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      send(STIM_W'(12'h200 + i), OUT_W'(20'hF0000), OUT_W'(20'hF0000 + i + 1), 1'b1);
    end
    log_ready = 1'b1;
    send(12'h2AA, 20'h55555, 20'hAAAAA, 1'b1);
    wait_done(20);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_fail", fail_count, 5);
    check("fullpop_all_popped", exp_q.size(), 0);

    // run_len = 0
    start_run(20'd0);
    in_valid = 1'b1;
    wait_done(10);
    in_valid = 1'b0;
    check("zero_vec", vec_count, 0);
    check("zero_pass", pass, 1);

    // Reset mid-run
    log_ready = 1'b0;
    start_run(20'd8);
    send(12'h301, 20'h00001, 20'h00003, 1'b1);
    send(12'h302, 20'h00001, 20'h00005, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_log_valid", log_valid, 0);
    check("midrst_vec", vec_count, 0);
    check("midrst_fail", fail_count, 0);
    check("midrst_stim", log_stim, 0);
    check("midrst_done", done, 0);
    tick(); tick();
    check("midrst_idle_in_ready", in_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/equiv_result_logger.md
# equiv_result_logger

Synthesizable response-side companion to the equivalence stimulus benches. It accepts one vector per handshake: the stimulus word plus the outputs of the spec and impl instances. It compares the two outputs bit-exactly and counts vectors and mismatches. The first DEPTH failing vectors are buffered in a FIFO that a host drains over a valid/ready port. Runs are bounded by a programmed vector count and end in a pass/fail verdict.

## Interface
- STIM_W, 12, stimulus word width (packed {a, n1, n2}).
- OUT_W, 20, width of the packed output vector ({o1..o5}).
- DEPTH, 4, failure-log FIFO entries; power of two, ≥2.
- CNT_W, 20, width of the vector and failure counters and of run_len.

- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- run_start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- run_len  input  CNT_W  number of vectors in the run; sampled on run_start.
- in_valid  input  1  vector present.
- in_ready  output  1  vector accepted when in_valid && in_ready.
- in_stim  input  STIM_W  stimulus applied for this vector.
- spec_out  input  OUT_W  reference-model outputs.
- impl_out  input  OUT_W  implementation outputs.
- log_valid  output  1  FIFO head is valid.
- log_ready  input  1  host pops the head when log_valid && log_ready.
- log_stim  output  STIM_W  stimulus of the head entry.
- log_spec  output  OUT_W  spec outputs of the head entry.
- log_impl  output  OUT_W  impl outputs of the head entry.
- log_index  output  CNT_W  0-based vector number of the head entry.
- log_diff  output  OUT_W  spec_out ^ impl_out of the head entry (see Configuration).
- vec_count  output  CNT_W  vectors accepted this run.
- fail_count  output  CNT_W  mismatching vectors this run; saturates at all-ones.
- overflow  output  1  sticky; a failure was dropped because the FIFO was full.
- done  output  1  high in state DONE.
- pass  output  1  in DONE, equals fail_count == 0; 0 outside DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on run_start.
- On the start cycle:
  - run_len is latched into remaining.
  - vec_count, fail_count and overflow clear.
  - The FIFO is flushed.
- RUN:
  - in_ready = 1.
  - Each accept increments vec_count (saturating) and decrements remaining.
  - The accept of the vector that makes remaining 0 moves the state to DRAIN.
  - If run_len = 0, RUN → DRAIN on the next cycle with no vectors accepted.
- DRAIN:
  - in_ready = 0.
  - DRAIN → DONE on the first cycle the FIFO is empty and no failure push is pending.
- DONE:
  - done = 1; pass is valid.
  - run_start → RUN, with the same clears as from IDLE.
- run_start is ignored in RUN and DRAIN.
- Mismatch condition: spec_out != impl_out, compared over all OUT_W bits.
- On a mismatch:
  - fail_count increments, saturating.
  - An entry {in_stim, spec_out, impl_out, index = vec_count before increment, diff} is pushed.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and overflow is set. fail_count still increments.
  - A push and a pop in the same cycle on a full FIFO are both performed.
- Vectors with in_valid while in_ready = 0 are not consumed and have no effect.
- The log outputs are stable while log_valid && !log_ready.

## Timing
- Reset: IDLE, in_ready = 0, log_valid = 0, and every counter, flag and log output 0.
- Reset mid-run aborts the run immediately. FIFO contents are discarded.
- Accept in cycle N:
  - vec_count updates in N+1.
  - fail_count updates in N+1.
  - The failure entry is visible at the head in N+1 if the FIFO was empty.
- The comparison is registered once; no combinational path from spec_out or impl_out to the log outputs.
- Pop in cycle N: the next entry (or log_valid = 0) appears in N+1.
- DONE is reached no earlier than 2 cycles after the last accept.

## Configuration
- EQUIV_LOG_DIFF_EN defined:
  - The FIFO stores the diff field.
  - log_diff carries the head entry's spec_out ^ impl_out.
- Undefined:
  - No diff storage.
  - log_diff is tied to 0.
  - All other behaviour is identical.

## Test plan
- All-pass run: reset, run_len = 8, 8 vectors with spec_out == impl_out. Require vec_count = 8, fail_count = 0, log_valid never high, done = 1, pass = 1.
- Single failure: run_len = 4, vector index 2 has stim 12'hA5C, spec 20'h12345, impl 20'h12305. Require log_index = 2, log_stim = 12'hA5C, log_diff = 20'h00040 (with macro), pass = 0 after drain.
- Overflow: DEPTH = 4, log_ready held 0, 6 failing vectors. Require fail_count = 6, overflow = 1, exactly 4 entries with indices 0..3 popped afterwards in order.
- Full FIFO with simultaneous pop: a push and a pop in the same cycle on a full FIFO. Require no overflow and the new entry retained.
- Backpressure and drain: in_valid high while in DRAIN is not consumed. log_ready toggling holds the head stable. DONE occurs only after the last pop.
- Edge cases:
  - run_len = 0 reaches DONE with pass = 1 and vec_count = 0.
  - Reset asserted mid-RUN returns to IDLE with all outputs 0.
  - run_start in DONE restarts with cleared counters.
